mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Multi-cycle sequencer for the CPU's 32x32 signed Booth multiplier. Accepts a start request with two operands and holds them stable on the multiplier inputs for a fixed settle window. Captures the 64-bit product into HI/LO result registers and signals completion with a one-cycle done pulse. Sits between the control unit and the multiplier, so the combinational multiply never lies on a single-cycle path.

## Interface
- MUL_CYCLES, 2, cycles the multiplier product is allowed to settle (legal range 1..15)
- clk  in  1  system clock, rising edge
- clr  in  1  reset; asynchronous and active-high
- start  in  1  request a multiply; sampled only in IDLE
- abort  in  1  cancel the in-flight multiply; sampled only in WAIT
- a  in  32  multiplicand (signed)
- b  in  32  multiplier (signed)
- mul_q  out  32  registered multiplicand driven to the multiplier
- mul_b  out  32  registered multiplier driven to the multiplier
- mul_z  in  64  signed product returned from the multiplier
- busy  out  1  high while in WAIT
- done  out  1  one-cycle pulse after a result is captured
- hi  out  32  product[63:32], registered
- lo  out  32  product[31:0], registered
- ovf  out  1  high when the product does not fit in 32 signed bits: hi != {32{lo[31]}}

## Operation
- Two states, IDLE and WAIT, plus a 4-bit down-counter cnt.
- **IDLE, start=1:** at the clock edge, latch a→mul_q and b→mul_b, load cnt=MUL_CYCLES-1, and go to WAIT.
- **IDLE, start=0:** hold all state.
- **WAIT, abort=1:** go to IDLE. No capture and no done; hi/lo/ovf keep their previous values. mul_q/mul_b hold.
- **WAIT, abort=0, cnt!=0:** decrement cnt.
- **WAIT, abort=0, cnt==0:** capture hi<=mul_z[63:32], lo<=mul_z[31:0], ovf<=computed flag; set done<=1 and go to IDLE.
- abort takes priority over capture when both apply in the same cycle.
- start is ignored while in WAIT: no queueing and no operand update.
- abort is ignored while in IDLE. If start and abort are both high in IDLE, the start is accepted.
- mul_q/mul_b change only on an accepted start, so they are stable for the whole WAIT window.
- The product is treated as full 64-bit two's complement; no saturation or truncation.

## Timing
- **Reset (clr=1, asynchronous):**
  - state=IDLE, cnt=0, busy=0, done=0
  - mul_q=0, mul_b=0, hi=0, lo=0, ovf=0
- Reset asserted mid-operation discards the operation; no done follows.
- **Latency:** start is sampled at edge E0; capture happens at edge E(MUL_CYCLES).
  - done is high for exactly one cycle after E(MUL_CYCLES).
  - hi/lo/ovf are valid from that same cycle.
- busy rises after E0 and falls after E(MUL_CYCLES), in the same cycle done rises.
- **Back-to-back:** start may be high in the done cycle (state is IDLE) and is accepted. Issue interval is MUL_CYCLES+1 cycles.
- **MUL_CYCLES=1:** WAIT lasts one cycle and captures at E1.
- busy and done are never high together. done is low in every cycle that is not immediately after a capture.
- No combinational path from any input to any output.

## Test plan
- **Signed multiply:** reset, then start with a=7, b=-3 (0xFFFFFFFD), MUL_CYCLES=2.
  - done pulses one cycle, two edges after start.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB, ovf=0.
- **Extreme operands:** a=b=0x80000000 → hi=0x40000000, lo=0x00000000, ovf=1.
- **Second extreme case:** a=0x7FFFFFFF, b=2 → hi=0x00000000, lo=0xFFFFFFFE, ovf=1.
- **Start while busy:** hold start high and change a/b during WAIT.
  - mul_q/mul_b stay at the first operands.
  - Exactly one done per issue, with interval MUL_CYCLES+1 cycles.
  - Result matches the first operands.
- **Back-to-back:** first issue a=5, b=6; second issue (start during its done cycle) a=-1, b=-1.
  - First result lo=30.
  - Second done arrives MUL_CYCLES+1 cycles later with hi=0, lo=1.
- **Abort and reset:**
  - After a prior result of 30, abort in the first WAIT cycle → no done, busy drops, hi/lo stay 0/30.
  - Separately, assert clr mid-WAIT → all outputs 0 immediately (asynchronous) and no done afterwards.

Source files
------------

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Multi-cycle sequencer for the 32x32 signed multiplier. Holds the
//            operands stable for a settle window, captures the 64-bit product
//            into HI/LO and flags completion with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
  parameter int MUL_CYCLES = 2  // settle window in cycles, legal 1..15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_q,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ovf
);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_WAIT     = 1'b1;
  localparam logic [3:0] c_CNT_LOAD = 4'(MUL_CYCLES - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_mul_q;
  logic [31:0] r_mul_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_ovf;
  logic        r_done;
  logic        w_accept;
  logic        w_capture;
  logic        w_ovf;

  // Qualified events: start only counts in IDLE; abort beats capture in WAIT.
  assign w_accept  = (r_state == c_IDLE) && start;
  assign w_capture = (r_state == c_WAIT) && !abort && (r_cnt == 4'd0);

  // Product overflows 32 signed bits when the upper word is not a pure
  // sign extension of the lower word.
  assign w_ovf = (mul_z[63:32] != {32{mul_z[31]}});

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave WAIT on abort or when the window expires.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (start) w_next_state = c_WAIT;
      c_WAIT: if (abort || (r_cnt == 4'd0)) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output decode: busy is a pure function of the registered state.
  always_comb begin
    busy = 1'b0;
    if (r_state == c_WAIT) busy = 1'b1;
  end

  // Settle counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_CNT_LOAD;
    end else if ((r_state == c_WAIT) && !abort && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Operand latches: only an accepted start updates them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_mul_q <= 32'd0;
      r_mul_b <= 32'd0;
    end else if (w_accept) begin
      r_mul_q <= a;
      r_mul_b <= b;
    end
  end

  // Result capture; aborted operations leave HI/LO/ovf untouched.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_hi  <= mul_z[63:32];
      r_lo  <= mul_z[31:0];
      r_ovf <= w_ovf;
    end
  end

  // Done pulse: high for exactly the cycle following a capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture;
    end
  end

  assign mul_q = r_mul_q;
  assign mul_b = r_mul_b;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign ovf   = r_ovf;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_ctrl
// Purpose  : Self-checking bench for mul_ctrl: directed scenarios plus random
//            traffic compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        abort;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] mul_q;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_rem;   // cycles left in the settle window, 0 = idle
  logic [31:0] m_q;
  logic [31:0] m_b;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ovf;
  logic        m_done;

  mul_ctrl #(.MUL_CYCLES(MUL_CYCLES)) u_dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .mul_q (mul_q),
    .mul_b (mul_b),
    .mul_z (mul_z),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational multiplier.
  assign mul_z = $signed({{32{mul_q[31]}}, mul_q}) * $signed({{32{mul_b[31]}}, mul_b});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_q = '0; m_b = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  task automatic check_all();
    chk("busy",  busy,  m_rem != 0);
    chk("done",  done,  m_done);
    chk("mul_q", mul_q, m_q);
    chk("mul_b", mul_b, m_b);
    chk("hi",    hi,    m_hi);
    chk("lo",    lo,    m_lo);
    chk("ovf",   ovf,   m_ovf);
  endtask

  // One clock: sample the driven inputs, advance the model, compare.
  task automatic step();
    logic        s, ab;
    logic [31:0] ta, tbv;
    longint      p;
    s = start; ab = abort; ta = a; tbv = b;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (m_rem == 0) begin
      if (s) begin
        m_q = ta; m_b = tbv; m_rem = MUL_CYCLES;
      end
    end else if (ab) begin
      m_rem = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        p      = longint'($signed(m_q)) * longint'($signed(m_b));
        m_hi   = p[63:32];
        m_lo   = p[31:0];
        m_ovf  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        m_done = 1'b1;
      end
    end
    check_all();
  endtask

  // Issue one multiply and run until its done cycle.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob);
    start = 1'b1; a = oa; b = ob;
    step();
    start = 1'b0;
    repeat (MUL_CYCLES) step();
  endtask

  initial begin
    int ndone;
    clr = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    clr = 1'b0;
    step();

    // Signed multiply 7 * -3
    run_op(32'd7, 32'hFFFF_FFFD);
    chk("sgn_done", done, 1'b1);
    chk("sgn_hi", hi, 32'hFFFF_FFFF);
    chk("sgn_lo", lo, 32'hFFFF_FFEB);
    chk("sgn_ovf", ovf, 1'b0);
    step();
    chk("sgn_done_low", done, 1'b0);

    // Extreme operands
    run_op(32'h8000_0000, 32'h8000_0000);
    chk("ext1_hi", hi, 32'h4000_0000);
    chk("ext1_lo", lo, 32'h0000_0000);
    chk("ext1_ovf", ovf, 1'b1);
    step();
    run_op(32'h7FFF_FFFF, 32'd2);
    chk("ext2_hi", hi, 32'h0000_0000);
    chk("ext2_lo", lo, 32'hFFFF_FFFE);
    chk("ext2_ovf", ovf, 1'b1);
    step();

    // Start held high while busy, operands changing every cycle
    ndone = 0;
    start = 1'b1; a = 32'd11; b = 32'd13;
    for (int i = 0; i < 2 * (MUL_CYCLES + 1); i++) begin
      step();
      if (done) ndone++;
      if (i == MUL_CYCLES) chk("hold_first_lo", lo, 32'd143);
      a = $urandom; b = $urandom;
    end
    chk("hold_dones", ndone, 2);
    start = 1'b0;
    repeat (MUL_CYCLES + 1) step();

    // Back-to-back: second start in the done cycle of the first
    run_op(32'd5, 32'd6);
    chk("b2b_lo1", lo, 32'd30);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_done2", done, 1'b1);
    chk("b2b_hi2", hi, 32'd0);
    chk("b2b_lo2", lo, 32'd1);
    step();

    // Abort in the first WAIT cycle after a result of 30
    run_op(32'd5, 32'd6);
    step();
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd30);
    repeat (MUL_CYCLES + 1) step();

    // Asynchronous reset mid-WAIT
    start = 1'b1; a = 32'd3; b = 32'd4;
    step();
    start = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_lo", lo, 32'd0);
    #1;
    clr = 1'b0;
    repeat (MUL_CYCLES + 2) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 9) < 4);
      abort = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 20)) - 10) : $urandom;
      step();
    end
    start = 1'b0; abort = 1'b0;
    repeat (MUL_CYCLES + 1) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
